// File: rtl/mpc_mem_pkg.sv
// Shared definitions for the MPC memory-side engines: default word and
// address widths, the snapshot-engine state encoding and the slack-region
// word-count helper used by both the z_prev writer and the residual check.
package mpc_mem_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    DRAIN      = 2'd2,
    DONE_STATE = 2'd3
  } mpc_state_e;

  // Words in the slack region: (min(horizon, max_horizon) - 1) * input_dim,
  // or zero when the clamped horizon leaves no inter-stage slack at all.
  function automatic logic [31:0] slack_region_words(
    input logic [31:0] horizon,
    input int unsigned max_horizon,
    input int unsigned input_dim
  );
    logic [31:0] h;
    h = (horizon > 32'(max_horizon)) ? 32'(max_horizon) : horizon;
    if (h <= 32'd1) begin
      return 32'd0;
    end
    return (h - 32'd1) * 32'(input_dim);
  endfunction

endpackage

// File: rtl/rd_delay_line.sv
// Tracks in-flight memory reads: a READ_LATENCY-deep shift register of
// {valid, address} so each returning read word can be paired with the index
// it was fetched from. busy is high while any stage still holds a read.
module rd_delay_line #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy
);

  logic [READ_LATENCY-1:0] valid_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg [READ_LATENCY];

  // Shift one stage per cycle; reset empties the line so no stale write fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        addr_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      addr_reg[0]  <= in_addr;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_reg[i] <= valid_reg[i-1];
        addr_reg[i]  <= addr_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[READ_LATENCY-1];
  assign out_addr  = addr_reg[READ_LATENCY-1];
  assign busy      = |valid_reg;

endmodule

// File: rtl/z_prev_writer.sv
// Snapshot engine: copies the slack region of z (indices k*INPUT_DIM+i,
// k < active_horizon-1) into z_prev at one word per cycle, so the next
// iteration's dual-residual check compares against this snapshot.
// Optional build macro Z_PREV_CLEAR_EN adds a 'clear' input; a pass started
// with clear=1 writes zeros over the region instead of copying (cold start).
module z_prev_writer
  import mpc_mem_pkg::*;
#(
  parameter int unsigned STATE_DIM    = 6,
  parameter int unsigned INPUT_DIM    = 3,
  parameter int unsigned HORIZON      = 30,
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef Z_PREV_CLEAR_EN
  input  logic                  clear,
`endif
  input  logic [31:0]           active_horizon,
  output logic [ADDR_WIDTH-1:0] z_rdaddress,
  input  logic [DATA_WIDTH-1:0] z_data_out,
  output logic [ADDR_WIDTH-1:0] z_prev_wraddress,
  output logic [DATA_WIDTH-1:0] z_prev_data_in,
  output logic                  z_prev_wren,
  output logic [ADDR_WIDTH-1:0] words_written,
  output logic                  done
);

  // Elaboration-time sanity checks on the parameter set.
  if (STATE_DIM == 0) begin : g_bad_state_dim
    $error("z_prev_writer: STATE_DIM must be at least 1");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("z_prev_writer: READ_LATENCY must be in 1..4");
  end
  if ((HORIZON - 1) * INPUT_DIM > (1 << ADDR_WIDTH)) begin : g_bad_region
    $error("z_prev_writer: slack region does not fit in ADDR_WIDTH");
  end

  mpc_state_e            state_reg;
  logic [31:0]           n_reg;
  logic [31:0]           addr_cnt_reg;
  logic [ADDR_WIDTH-1:0] wraddress_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  wren_reg;
  logic [ADDR_WIDTH-1:0] words_written_reg;
  logic                  done_reg;
  logic                  clear_mode;
  logic [31:0]           region_words;

  logic                  dl_in_valid;
  logic                  dl_out_valid;
  logic [ADDR_WIDTH-1:0] dl_out_addr;
  logic                  dl_busy;

  assign region_words = slack_region_words(active_horizon, HORIZON, INPUT_DIM);

`ifdef Z_PREV_CLEAR_EN
  logic clear_mode_reg;

  // Pass mode is fixed for the whole pass, captured alongside start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_mode_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      clear_mode_reg <= clear;
    end
  end

  assign clear_mode = clear_mode_reg;
`else
  assign clear_mode = 1'b0;
`endif

  // A read is in flight for every cycle spent issuing addresses.
  assign dl_in_valid = (state_reg == ISSUE);

  rd_delay_line #(
    .READ_LATENCY (READ_LATENCY),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_rd_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (dl_in_valid),
    .in_addr   (addr_cnt_reg[ADDR_WIDTH-1:0]),
    .out_valid (dl_out_valid),
    .out_addr  (dl_out_addr),
    .busy      (dl_busy)
  );

  // Pass sequencer plus the registered write port: read addresses go out
  // from ISSUE, returning words are committed as the delay line delivers them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      n_reg             <= '0;
      addr_cnt_reg      <= '0;
      wraddress_reg     <= '0;
      wdata_reg         <= '0;
      wren_reg          <= 1'b0;
      words_written_reg <= '0;
      done_reg          <= 1'b0;
    end else begin
      wren_reg <= dl_out_valid;
      if (dl_out_valid) begin
        wraddress_reg     <= dl_out_addr;
        wdata_reg         <= clear_mode ? '0 : z_data_out;
        words_written_reg <= words_written_reg + ADDR_WIDTH'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            n_reg             <= region_words;
            addr_cnt_reg      <= '0;
            words_written_reg <= '0;
            if (region_words == 32'd0) begin
              // Nothing to copy: report completion straight away.
              state_reg <= DONE_STATE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (addr_cnt_reg == n_reg - 32'd1) begin
            state_reg <= DRAIN;
          end else begin
            addr_cnt_reg <= addr_cnt_reg + 32'd1;
          end
        end
        DRAIN: begin
          // Line empty means the final write is on the port this cycle.
          if (!dl_busy) begin
            state_reg <= DONE_STATE;
            done_reg  <= 1'b1;
          end
        end
        DONE_STATE: begin
          if (!start) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign z_rdaddress      = addr_cnt_reg[ADDR_WIDTH-1:0];
  assign z_prev_wraddress = wraddress_reg;
  assign z_prev_data_in   = wdata_reg;
  assign z_prev_wren      = wren_reg;
  assign words_written    = words_written_reg;
  assign done             = done_reg;

endmodule

// File: tb/tb_z_prev_writer.sv
// Self-checking bench for z_prev_writer: a z memory model with configurable
// read latency, a z_prev memory model, and a scoreboard of expected writes
// (address, data, cycle, running count) pushed when each pass is started.
module tb_z_prev_writer;

  localparam int RL    = 2;
  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam logic [DW-1:0] SENT = 64'hDEAD_BEEF_CAFE_F00D;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    longint        cyc;
    int            cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          clear_sig;
  logic [31:0]   active_horizon;
  logic [AW-1:0] z_rdaddress;
  logic [DW-1:0] z_data_out;
  logic [AW-1:0] z_prev_wraddress;
  logic [DW-1:0] z_prev_data_in;
  logic          z_prev_wren;
  logic [AW-1:0] words_written;
  logic          done;

  logic [DW-1:0] z_mem [DEPTH];
  logic [DW-1:0] zp [DEPTH];
  logic [DW-1:0] rd_pipe [RL];
  logic          zp_wipe;
  longint        cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          sb_q [$];

  z_prev_writer #(
    .STATE_DIM    (6),
    .INPUT_DIM    (3),
    .HORIZON      (30),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
`ifdef Z_PREV_CLEAR_EN
    .clear            (clear_sig),
`endif
    .active_horizon   (active_horizon),
    .z_rdaddress      (z_rdaddress),
    .z_data_out       (z_data_out),
    .z_prev_wraddress (z_prev_wraddress),
    .z_prev_data_in   (z_prev_data_in),
    .z_prev_wren      (z_prev_wren),
    .words_written    (words_written),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // z memory: registered read with RL cycles of latency.
  always @(posedge clk) begin
    rd_pipe[0] <= z_mem[z_rdaddress];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign z_data_out = rd_pipe[RL-1];

  // z_prev memory model.
  always @(posedge clk) begin
    if (zp_wipe) begin
      for (int i = 0; i < DEPTH; i++) zp[i] <= SENT;
    end else if (z_prev_wren) begin
      zp[z_prev_wraddress] <= z_prev_data_in;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every presented write must match the next expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && z_prev_wren) begin
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 64'(z_prev_wraddress), 64'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 64'(z_prev_wraddress), 64'(e.addr));
        chk("wr_data", z_prev_data_in, e.data);
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr_count", 64'(words_written), 64'(e.cnt));
      end
    end
  end

  task automatic wipe_zp();
    @(negedge clk) zp_wipe = 1'b1;
    @(negedge clk) zp_wipe = 1'b0;
  endtask

  function automatic int region_n(input logic [31:0] hor);
    int h;
    h = (hor > 32'd30) ? 30 : int'(hor);
    return (h <= 1) ? 0 : (h - 1) * 3;
  endfunction

  // Start one pass, queue its expected writes, wait for done and check it.
  task automatic run_pass(input logic [31:0] hor, input bit clr, input bit mid_pulse, input int hold);
    int     n;
    longint c0;
    longint exp_done;
    longint got_done;
    bit     seen;
    int     bad;
    exp_t   e;
    wipe_zp();
    n = region_n(hor);
    @(negedge clk);
    active_horizon = hor;
    clear_sig      = clr;
    start          = 1'b1;
    c0             = cyc + 1;
    for (int j = 0; j < n; j++) begin
      e.addr = AW'(j);
      e.data = clear_sig ? 64'd0 : 64'(j + 100);
      e.cyc  = c0 + longint'(j) + 1 + RL;
      e.cnt  = j + 1;
      sb_q.push_back(e);
    end
    exp_done = (n == 0) ? c0 : c0 + longint'(n) + RL + 1;
    seen = 1'b0;
    got_done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        got_done = cyc;
        break;
      end
      if (mid_pulse) start = ((cyc - c0 + 1) == 4);
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    chk("done_cycle", 64'(got_done - c0 + 1), 64'(exp_done - c0 + 1));
    chk("words_final", 64'(words_written), 64'(n));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("done_hold", 64'(done), 64'd1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_drop", 64'(done), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    bad = 0;
    for (int j = 0; j < n; j++) begin
      if (zp[j] !== (clr ? 64'd0 : 64'(j + 100))) bad++;
    end
    chk("zp_region", 64'(bad), 64'd0);
    chk("zp_beyond", zp[n], SENT);
    $display("pass horizon=%0d clear=%0d n=%0d done_cycle=%0d words=%0d",
             hor, clr, n, got_done - c0 + 1, words_written);
  endtask

  initial begin
    longint c0;
    for (int i = 0; i < DEPTH; i++) z_mem[i] = 64'(i + 100);
    rst_n          = 1'b0;
    start          = 1'b0;
    clear_sig      = 1'b0;
    active_horizon = 32'd0;
    zp_wipe        = 1'b0;
    #1;
    chk("rst_rdaddr", 64'(z_rdaddress), 64'd0);
    chk("rst_wren", 64'(z_prev_wren), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_wdata", z_prev_data_in, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_pass(32'd4, 1'b0, 1'b0, 3);    // basic 9-word copy, start held after done
    run_pass(32'd1, 1'b0, 1'b0, 0);    // empty region
    run_pass(32'd0, 1'b0, 1'b0, 0);    // empty region
    run_pass(32'd50, 1'b0, 1'b0, 0);   // clamp to HORIZON, n = 87
    chk("clamp_last", zp[86], 64'd186);
    run_pass(32'd4, 1'b0, 1'b1, 0);    // start re-pulsed mid-pass

    // Reset during cycle 6 of a 9-word pass.
    wipe_zp();
    @(negedge clk);
    active_horizon = 32'd4;
    start = 1'b1;
    c0 = cyc + 1;
    for (int j = 0; j < 9; j++) begin
      sb_q.push_back('{addr: AW'(j), data: 64'(j + 100), cyc: c0 + longint'(j) + 1 + RL, cnt: j + 1});
    end
    for (int k = 0; k < 20 && (cyc - c0 + 1) < 6; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wren", 64'(z_prev_wren), 64'd0);
    chk("mid_rst_rdaddr", 64'(z_rdaddress), 64'd0);
    chk("mid_rst_wraddr", 64'(z_prev_wraddress), 64'd0);
    chk("mid_rst_wdata", z_prev_data_in, 64'd0);
    chk("mid_rst_words", 64'(words_written), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    sb_q.delete();
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_part0", zp[0], 64'd100);
    chk("mid_rst_part1", zp[1], 64'd101);
    chk("mid_rst_part2", zp[2], SENT);
    $display("reset mid-pass at cycle 6, partial writes kept");
    run_pass(32'd4, 1'b0, 1'b0, 0);    // full redo after reset

`ifdef Z_PREV_CLEAR_EN
    run_pass(32'd4, 1'b1, 1'b0, 0);    // clear pass: zeros, same timing
    run_pass(32'd4, 1'b0, 1'b0, 0);    // back to copying
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/z_prev_writer.md
# z_prev_writer

Snapshot engine that copies the current slack vector z into the z_prev buffer at the end of each ADMM iteration, so the dual-residual check in the next iteration compares z against this snapshot. It sits between the slack-update stage and the residual check. It streams z out of the z memory read port and into the z_prev memory write port at one word per cycle through a fixed-latency pipeline. It covers exactly the region the residual check reads: indices k*INPUT_DIM+i for k < active_horizon-1 and i < INPUT_DIM.

## Interface
- STATE_DIM, 6, state dimension (nx); kept for parameter-list uniformity, unused in addressing
- INPUT_DIM, 3, input dimension (nu)
- HORIZON, 30, maximum MPC horizon (N)
- DATA_WIDTH, 64, word width
- ADDR_WIDTH, 9, memory address width
- READ_LATENCY, 2, cycles from z_rdaddress to valid z_data_out (1..4)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level request; sampled in IDLE
- active_horizon  in  32  horizon length; sampled at start
- z_rdaddress  out  ADDR_WIDTH  z memory read address
- z_data_out  in  DATA_WIDTH  z memory read data
- z_prev_wraddress  out  ADDR_WIDTH  z_prev write address
- z_prev_data_in  out  DATA_WIDTH  z_prev write data
- z_prev_wren  out  1  z_prev write enable
- words_written  out  ADDR_WIDTH  count of writes committed in the current pass
- done  out  1  pass complete; held until start deasserts

## Operation
- States:
  - IDLE: waits for start.
  - ISSUE: presents one read address per cycle.
  - DRAIN: waits for in-flight reads to be written.
  - DONE_STATE: raises done.
- IDLE → ISSUE on start. On that transition:
  - latch n = (min(active_horizon, HORIZON) - 1) * INPUT_DIM;
  - clear words_written and the address counter.
- If active_horizon ≤ 1, n = 0. The block goes IDLE → DONE_STATE directly, issues no reads and performs no writes.
- ISSUE:
  - drives z_rdaddress = 0, 1, …, n-1 on consecutive cycles;
  - pushes (valid=1, address) into a READ_LATENCY-deep delay line;
  - moves to DRAIN after address n-1 is issued.
- Delay-line output with valid=1 causes a registered write: z_prev_wraddress = delayed address, z_prev_data_in = z_data_out, z_prev_wren = 1, words_written += 1.
- DRAIN → DONE_STATE once the delay line is empty and the last write has been presented.
- DONE_STATE:
  - done = 1;
  - when start is low: done = 0, go to IDLE.
- start asserted in any state other than IDLE is ignored. There is no abort input.
- Address arithmetic runs at 32 bits and is truncated to ADDR_WIDTH. The index range must satisfy (HORIZON-1)*INPUT_DIM ≤ 2^ADDR_WIDTH.

## Timing
- Reset values:
  - z_rdaddress = 0, z_prev_wraddress = 0, z_prev_data_in = 0;
  - z_prev_wren = 0, words_written = 0, done = 0;
  - state = IDLE; delay line cleared.
- Cycle numbering: start is sampled at edge E0. z_rdaddress = j during cycle j+1, for j = 0..n-1.
- z_data_out for address j is valid in cycle j+1+READ_LATENCY.
- The write for address j is presented (z_prev_wren high) in cycle j+2+READ_LATENCY.
- z_prev_wren is high for exactly n consecutive cycles, with no bubbles.
- done rises in cycle n+READ_LATENCY+2. Total latency from start is n+READ_LATENCY+2 cycles.
- For n = 0, done rises in cycle 1.
- Reset asserted mid-pass: all outputs return to their reset values asynchronously, z_prev_wren drops immediately, and partial z_prev contents are left as written.
- Read and write to the same index never occur in the same cycle. The memories are distinct.

## Configuration
- Z_PREV_CLEAR_EN defined:
  - adds input port clear (1 bit), sampled together with start;
  - when clear = 1 at start, the pass writes DATA_WIDTH'(0) to every index in the region;
  - same address sequence and timing as a copy pass, with z_data_out ignored;
  - used for cold starts.
- Undefined: no clear port; every pass is a copy pass.

## Structure
- Shared package mpc_mem_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - state enum typedef for IDLE/ISSUE/DRAIN/DONE_STATE;
  - function computing the slack-region word count from horizon and INPUT_DIM (also used by the residual check).
- One sub-module: rd_delay_line. It is a parameterised READ_LATENCY-deep shift register of {valid, ADDR_WIDTH address}, reset asynchronously to all-invalid.

## Test plan
- INPUT_DIM=3, READ_LATENCY=2, active_horizon=4, z[j]=j+100:
  - n=9; z_prev[0..8]=100..108;
  - wren high cycles 4..12; done rises in cycle 13; words_written=9.
- active_horizon=1 or 0: no wren pulse, done in cycle 1, words_written=0.
- active_horizon=50 with HORIZON=30: clamps to n=87; last write to address 86; z_prev[87] untouched.
- Pulse start again mid-pass (cycle 5): ignored, and the sequence is unchanged.
- Hold start high after done: done stays 1. Drop start: done is 0 the next cycle and the block returns to IDLE.
- rst_n low in cycle 6 of a 9-word pass:
  - wren drops immediately and all outputs go to reset values;
  - a subsequent start redoes all 9 writes.
- Z_PREV_CLEAR_EN with clear=1: all 9 z_prev words are 0 with identical timing.
